// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared execute-stage types for the RV32M sequencer
package core_types_pkg;

  localparam int N_BITS        = 32;
  localparam int MULDIV_CYCLES = N_BITS;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_fn_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider datapath
// acc holds {carry, hi, lo}: product accumulator for multiply, {rem, quot} for divide.
module muldiv_iter #(
  parameter int N = core_types_pkg::N_BITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [N-1:0]   mag1,
  input  logic [N-1:0]   mag2,
  output logic [2*N-1:0] raw
);

  logic [2*N:0] acc_q, acc_d;
  logic [N-1:0] opb_q, opb_d;
  logic [N:0]   sum;
  logic [N:0]   rem_sh;
  logic [N-1:0] diff;

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    sum    = acc_q[2*N:N] + {1'b0, opb_q};
    rem_sh = acc_q[2*N-1:N-1];
    diff   = rem_sh[N-1:0] - opb_q;
    if (load) begin
      acc_d = {{(N+1){1'b0}}, mag1};
      opb_d = mag2;
    end else if (step) begin
      if (is_div) begin
        if (rem_sh >= {1'b0, opb_q}) begin
          acc_d = {1'b0, diff, acc_q[N-2:0], 1'b1};
        end else begin
          acc_d = {1'b0, rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
        end
      end else if (acc_q[0]) begin
        acc_d = {1'b0, sum, acc_q[N-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*N:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  // Post-step value, so the controller can register the result on the last iteration.
  assign raw = acc_d[2*N-1:0];

endmodule

// File: rtl/x_muldiv_ctrl.sv
// rtl/x_muldiv_ctrl.sv - RV32M multiply/divide sequencer beside the execute-stage ALU
// Owns the FSM, iteration counter, sign handling, divide fast paths and result mux.
module x_muldiv_ctrl #(
  parameter int N_BITS = core_types_pkg::N_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  input  core_types_pkg::muldiv_fn_t  fn,
  input  logic [N_BITS-1:0]           op1,
  input  logic [N_BITS-1:0]           op2,
  input  logic                        kill,
  output logic                        stall_req,
  output logic [N_BITS-1:0]           result,
  output logic                        result_vld
);

  import core_types_pkg::*;

  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [N_BITS-1:0] MIN_NEG = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} muldiv_state_t;

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  muldiv_fn_t        fn_q, fn_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [N_BITS-1:0] result_q, result_d;

  logic                start;
  logic                sgn1, sgn2;
  logic                div_zero, div_ovf;
  logic [N_BITS-1:0]   mag1, mag2;
  logic [N_BITS-1:0]   fast_val, final_val;
  logic [N_BITS-1:0]   quot, rem;
  logic [2*N_BITS-1:0] raw, prod;

  assign start = (state_q == S_IDLE) && req_vld && !kill;

  assign sgn1 = op1[N_BITS-1] && (fn inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign sgn2 = op2[N_BITS-1] && (fn inside {MD_MULH, MD_DIV, MD_REM});
  assign mag1 = sgn1 ? -op1 : op1;
  assign mag2 = sgn2 ? -op2 : op2;

  assign div_zero = fn[2] && (op2 == '0);
  assign div_ovf  = (fn inside {MD_DIV, MD_REM}) && (op1 == MIN_NEG) && (op2 == '1);

  // Divide by zero wins over overflow; both bypass the iterator entirely.
  always_comb begin
    fast_val = '0;
    if (fn inside {MD_DIV, MD_DIVU}) begin
      fast_val = div_zero ? '1 : MIN_NEG;
    end else if (div_zero) begin
      fast_val = op1;
    end
  end

  assign prod = (s1_q ^ s2_q) ? -raw : raw;
  assign quot = (s1_q ^ s2_q) ? -raw[N_BITS-1:0] : raw[N_BITS-1:0];
  assign rem  = s1_q ? -raw[2*N_BITS-1:N_BITS] : raw[2*N_BITS-1:N_BITS];

  always_comb begin
    final_val = '0;
    case (fn_q)
      MD_MUL:                       final_val = prod[N_BITS-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_val = prod[2*N_BITS-1:N_BITS];
      MD_DIV, MD_DIVU:              final_val = quot;
      MD_REM, MD_REMU:              final_val = rem;
      default:                      final_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fn_d = fn;
          s1_d = sgn1;
          s2_d = sgn2;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = fast_val;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CW'(MULDIV_CYCLES);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = final_val;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fn_q     <= MD_MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
    end
  end

  muldiv_iter #(.N(N_BITS)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (state_q == S_BUSY),
    .is_div (fn_q[2]),
    .mag1   (mag1),
    .mag2   (mag2),
    .raw    (raw)
  );

  assign stall_req  = req_vld && !kill && (state_q != S_DONE);
  assign result_vld = (state_q == S_DONE) && !kill;
  assign result     = result_q;

  // The X stage must keep the instruction presented until it completes or is squashed.
  req_held_while_busy: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_BUSY && !kill) |-> req_vld);

endmodule
